// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding and the fixed bus addresses
// involved in a sprite DMA.
package nes_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side bus signals seen by the OAM DMA sequencer.
// master = the DMA block; slave = the system/top level that owns WRAM and the mux.
interface oam_dma_ctrl_if;

    logic        ce;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  bus_rdata;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_wdata;
    logic        dma_done;

    modport master (
        input  ce, cpu_addr, cpu_we, cpu_wdata, bus_rdata,
        output cpu_rdy, dma_active, dma_addr, dma_we, dma_wdata, dma_done
    );

    modport slave (
        output ce, cpu_addr, cpu_we, cpu_wdata, bus_rdata,
        input  cpu_rdy, dma_active, dma_addr, dma_we, dma_wdata, dma_done
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA sequencer. A CPU write to DMA_REG_ADDR halts the CPU and
// copies 256 bytes from page {page,8'h00} to OAM_DATA_ADDR, one read/write
// pair per byte, with an optional alignment cycle set by the get/put parity.
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = OAMDMA_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = OAMDATA_ADDR
) (
    input  logic          clk,
    input  logic          reset_n,
    oam_dma_ctrl_if.master bus
);

    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic       parity_q, parity_d;
    logic       done_q, done_d;

    // State register; everything advances only on a CPU-cycle enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= DMA_IDLE;
            idx_q    <= 8'h00;
            page_q   <= 8'h00;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.ce) begin
            // NOTE: non-blocking here so every flop samples pre-edge values.
            state_q  <= state_d;
            idx_q    <= idx_d;
            page_q   <= page_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: trigger detection, alignment decision and byte counting.
    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        page_d   = page_q;
        parity_d = ~parity_q;
        done_d   = 1'b0;

        unique case (state_q)
            DMA_IDLE: begin
                if (bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = bus.cpu_wdata;
                    state_d = DMA_HALT;
                end
            end
            DMA_HALT:  state_d = parity_q ? DMA_ALIGN : DMA_READ;
            DMA_ALIGN: state_d = DMA_READ;
            DMA_READ:  state_d = DMA_WRITE;
            DMA_WRITE: begin
                if (idx_q == 8'hFF) begin
                    idx_d   = 8'h00;
                    done_d  = 1'b1;
                    state_d = DMA_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = DMA_READ;
                end
            end
            default:   state_d = DMA_IDLE;
        endcase
    end

    // Bus outputs decoded from the registered state, so they freeze with ce=0.
    // HALT/ALIGN already present the first source address rather than $0000.
    always_comb begin
        bus.cpu_rdy    = 1'b1;
        bus.dma_active = 1'b0;
        bus.dma_addr   = 16'h0000;
        bus.dma_we     = 1'b0;
        bus.dma_wdata  = 8'h00;
        bus.dma_done   = done_q;

        unique case (state_q)
            DMA_IDLE: ;
            DMA_HALT, DMA_ALIGN, DMA_READ: begin
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
                bus.dma_addr   = {page_q, idx_q};
            end
            DMA_WRITE: begin
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
                bus.dma_addr   = OAM_DATA_ADDR;
                bus.dma_we     = 1'b1;
                bus.dma_wdata  = bus.bus_rdata;
            end
            default: ;
        endcase
    end

endmodule
